// File: rtl/cpu_dbg_pkg.sv
// ============================================================================
// Module : cpu_dbg_pkg
// Shared run-state and trace-entry types for the CPU run monitor.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package cpu_dbg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BOOT = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } run_state_t;

  localparam int TRACE_DW = 32;

  typedef struct packed {
    logic [TRACE_DW-1:0] pc;
    logic [TRACE_DW-1:0] ins;
    logic [TRACE_DW-1:0] result;
  } trace_entry_t;

endpackage

`default_nettype wire

// File: rtl/cpu_run_monitor_trace_ring.sv
// ============================================================================
// Module : trace_ring
// Circular trace store with saturating count, wrap flag and oldest-relative read.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module trace_ring #(
  parameter int DW    = 32,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_clear,
  input  logic                       i_we,
  input  logic [3*DW-1:0]            i_wdata,
  input  logic [$clog2(DEPTH)-1:0]   i_rd_idx,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_wrapped,
  output logic [3*DW-1:0]            o_rdata
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

  logic [3*DW-1:0] r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW:0]     r_count;
  logic            r_wrapped;
  logic [AW-1:0]   w_phys;
  logic            w_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_wrapped <= 1'b0;
    end else if (i_clear) begin
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_wrapped <= 1'b0;
    end else if (i_we) begin
      r_wr_ptr <= r_wr_ptr + AW'(1);
      if (r_count == C_FULL) begin
        r_wrapped <= 1'b1;
      end else begin
        r_count <= r_count + (AW+1)'(1);
      end
    end
  end

  // Storage is not reset; stale entries are hidden by the count gate.
  always_ff @(posedge clk) begin
    if (i_we && !i_clear) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Once wrapped the write pointer points at the oldest entry.
  assign w_phys  = r_wrapped ? (r_wr_ptr + i_rd_idx) : i_rd_idx;
  assign w_valid = ({1'b0, i_rd_idx} < r_count);

  assign o_rdata   = w_valid ? r_mem[w_phys] : '0;
  assign o_count   = r_count;
  assign o_wrapped = r_wrapped;

endmodule

`default_nettype wire

// File: rtl/cpu_run_monitor.sv
// ============================================================================
// Module : cpu_run_monitor
// Core reset sequencer, run/instruction counters, PC trace capture and halt detect.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cpu_run_monitor
  import cpu_dbg_pkg::*;
#(
  parameter int DW          = 32,
  parameter int DEPTH       = 16,
  parameter int BOOT_CYCLES = 2,
  parameter int STALL_LIMIT = 8,
  parameter int CW          = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     start,
  input  logic [DW-1:0]            boot_pc,
  output logic                     cpu_rst,
  output logic [DW-1:0]            outside_pc,
  input  logic [DW-1:0]            now_pc,
  input  logic [DW-1:0]            ins,
  input  logic [DW-1:0]            result,
  output logic                     halted,
  output logic [CW-1:0]            cycle_cnt,
  output logic [CW-1:0]            instr_cnt,
  output logic [$clog2(DEPTH):0]   trace_count,
  output logic                     wrapped,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [DW-1:0]            rd_pc,
  output logic [DW-1:0]            rd_ins,
  output logic [DW-1:0]            rd_result
);

  localparam int BW = $clog2(BOOT_CYCLES) + 1;
  localparam int SW = $clog2(STALL_LIMIT) + 1;

  run_state_t      r_state;
  logic            r_cpu_rst;
  logic            r_halted;
  logic [DW-1:0]   r_outside_pc;
  logic [CW-1:0]   r_cycle_cnt;
  logic [CW-1:0]   r_instr_cnt;
  logic [BW-1:0]   r_boot_cnt;
  logic [SW-1:0]   r_stall_cnt;
  logic            r_first;
  logic [DW-1:0]   r_pc_q;

  logic            w_restart;
  logic            w_event;
  logic [3*DW-1:0] w_rdata;

  // Restart beats a same-cycle event, so no trace write happens on a restart.
  assign w_restart = start && (r_state != BOOT);
  assign w_event   = (r_state == RUN) && !start && (r_first || (now_pc != r_pc_q));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state      <= IDLE;
      r_cpu_rst    <= 1'b1;
      r_halted     <= 1'b0;
      r_outside_pc <= '0;
      r_cycle_cnt  <= '0;
      r_instr_cnt  <= '0;
      r_boot_cnt   <= '0;
      r_stall_cnt  <= '0;
      r_first      <= 1'b0;
      r_pc_q       <= '0;
    end else if (w_restart) begin
      r_state      <= BOOT;
      r_cpu_rst    <= 1'b1;
      r_halted     <= 1'b0;
      r_outside_pc <= boot_pc;
      r_cycle_cnt  <= '0;
      r_instr_cnt  <= '0;
      r_boot_cnt   <= BW'(BOOT_CYCLES - 1);
      r_stall_cnt  <= '0;
      r_first      <= 1'b0;
    end else begin
      case (r_state)
        BOOT: begin
          if (r_boot_cnt == '0) begin
            r_state   <= RUN;
            r_cpu_rst <= 1'b0;
            r_first   <= 1'b1;
          end else begin
            r_boot_cnt <= r_boot_cnt - BW'(1);
          end
        end
        RUN: begin
          r_pc_q <= now_pc;
          if (r_cycle_cnt != '1) begin
            r_cycle_cnt <= r_cycle_cnt + CW'(1);
          end
          if (w_event) begin
            if (r_instr_cnt != '1) begin
              r_instr_cnt <= r_instr_cnt + CW'(1);
            end
            r_stall_cnt <= '0;
            r_first     <= 1'b0;
          end else begin
            r_stall_cnt <= r_stall_cnt + SW'(1);
            if (r_stall_cnt == SW'(STALL_LIMIT - 2)) begin
              r_state   <= HALT;
              r_halted  <= 1'b1;
              r_cpu_rst <= 1'b1;
            end
          end
        end
        IDLE, HALT: begin
          r_cpu_rst <= 1'b1;
        end
        default: begin
          r_state   <= IDLE;
          r_cpu_rst <= 1'b1;
        end
      endcase
    end
  end

  trace_ring #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_trace_ring (
    .clk       (CLK),
    .rst_n     (RST),
    .i_clear   (w_restart),
    .i_we      (w_event),
    .i_wdata   ({now_pc, ins, result}),
    .i_rd_idx  (rd_idx),
    .o_count   (trace_count),
    .o_wrapped (wrapped),
    .o_rdata   (w_rdata)
  );

  assign cpu_rst    = r_cpu_rst;
  assign outside_pc = r_outside_pc;
  assign halted     = r_halted;
  assign cycle_cnt  = r_cycle_cnt;
  assign instr_cnt  = r_instr_cnt;
  assign rd_pc      = w_rdata[3*DW-1:2*DW];
  assign rd_ins     = w_rdata[2*DW-1:DW];
  assign rd_result  = w_rdata[DW-1:0];

endmodule

`default_nettype wire

// File: doc/cpu_run_monitor.md
# cpu_run_monitor

Run controller and instruction-trace monitor that sits beside the multicycle CPU core (`Main`) in simulation and FPGA bring-up. It sequences the core's reset, supplies the boot PC on `outside_pc`, and counts cycles and retired instructions. It captures a circular trace of `{now_pc, ins, result}`, one entry per PC change, and declares halt when the PC stalls. It is a parametrised, synthesizable successor to the hand-written clock/reset stimulus, with capture and halt detection added.

## Interface
- `DW`, 32, datapath width of PC/instruction/result
- `DEPTH`, 16, trace entries; power of two, ≥2
- `BOOT_CYCLES`, 2, cycles `cpu_rst` is held after start; ≥1
- `STALL_LIMIT`, 8, consecutive cycles without PC change that declare halt; ≥2
- `CW`, 32, counter width

Ports:
- `CLK` in 1: clock, rising edge
- `RST` in 1: reset, asynchronous, active-low
- `start` in 1: one-cycle pulse that (re)starts a run
- `boot_pc` in DW: PC latched on `start`
- `cpu_rst` out 1: active-high reset to core
- `outside_pc` out DW: boot PC to core
- `now_pc` in DW, `ins` in DW, `result` in DW: core observation
- `halted` out 1: high in HALT
- `cycle_cnt` out CW: cycles spent in RUN
- `instr_cnt` out CW: trace events in the current run
- `trace_count` out $clog2(DEPTH)+1: valid entries, saturates at DEPTH
- `wrapped` out 1: buffer has overwritten at least once
- `rd_idx` in $clog2(DEPTH): 0 = oldest valid entry
- `rd_pc`, `rd_ins`, `rd_result` out DW: combinational read of entry `rd_idx`

## Operation
- States: IDLE, BOOT, RUN, HALT.
- Reset (`RST`=0) values:
  - state = IDLE, `cpu_rst`=1, `outside_pc`=0, `halted`=0
  - all counters 0, `wr_ptr`=0, `wrapped`=0
  - trace contents are don't-care but read as 0 via the `trace_count` gate.
- IDLE: `cpu_rst`=1. `start` → BOOT.
- Entering BOOT from any state:
  - latch `outside_pc`=`boot_pc`
  - clear `cycle_cnt`, `instr_cnt`, `trace_count`, `wr_ptr`, `wrapped`, stall counter
  - set boot counter = BOOT_CYCLES−1.
- BOOT: `cpu_rst`=1 and `start` is ignored. The boot counter decrements each cycle; at 0 → RUN and set `first`=1.
- RUN: `cpu_rst`=0 and `cycle_cnt`++ each cycle.
  - Event = `first` OR (`now_pc` ≠ `pc_q`), where `pc_q` is `now_pc` registered every RUN cycle.
  - On an event: write `{now_pc, ins, result}` at `wr_ptr`, `wr_ptr`++ (mod DEPTH), `instr_cnt`++, `trace_count`++ (saturating at DEPTH), clear stall counter, clear `first`.
  - `wrapped` sets when a write occurs with `trace_count`==DEPTH.
  - No event: stall counter++. When it reaches STALL_LIMIT−1 with no event → HALT.
  - `start` in RUN → BOOT; restart takes priority over an event in the same cycle.
- HALT: `halted`=1 and `cpu_rst`=1 to freeze the core. Counters and trace are frozen. `start` → BOOT.
- `cycle_cnt` and `instr_cnt` saturate at all-ones and do not wrap.
- Read addressing:
  - physical index = (`wrapped` ? `wr_ptr`+`rd_idx` : `rd_idx`) mod DEPTH.
  - If `rd_idx` ≥ `trace_count`, `rd_*` = 0.

## Timing
- All state, counters, and outputs are registered except `rd_*`, which are combinational from `rd_idx`.
- `start` sampled at edge k → BOOT after k. `cpu_rst` stays 1 for exactly BOOT_CYCLES cycles in BOOT, then falls at the edge entering RUN.
- Trace write occurs at the edge ending the event cycle. `rd_*`, `trace_count`, and `instr_cnt` reflect it in the following cycle.
- Halt latency: last event in cycle n → HALT entered at the edge ending cycle n+STALL_LIMIT−1... exact rule: HALT entered after STALL_LIMIT−1 consecutive non-event RUN cycles.
- Asynchronous `RST` mid-run forces IDLE immediately; `cpu_rst` rises asynchronously.

## Structure
- Shared package `cpu_dbg_pkg` holds:
  - state enum `run_state_t` {IDLE, BOOT, RUN, HALT}
  - `trace_entry_t` struct {pc, ins, result} sized by DW.
- One sub-module, `trace_ring`: DEPTH×3·DW storage with write pointer, `wrapped`/count logic, and oldest-relative read. The FSM and counters stay in the top.

## Test plan
- Reset then `start` with `boot_pc`=0x0000_0040, BOOT_CYCLES=2 → `outside_pc`=0x40; `cpu_rst` high exactly 2 cycles after start, then 0; `cycle_cnt` starts counting at 1.
- PC sequence 0x40, 0x40, 0x44, 0x48, 0x48 → `instr_cnt`=3; entries 0..2 have pc 0x40, 0x44, 0x48 with matching ins/result.
- DEPTH=16, 20 distinct PCs → `trace_count`=16, `wrapped`=1, `rd_idx`=0 returns the 5th PC and `rd_idx`=15 returns the 20th.
- PC held 8 cycles with STALL_LIMIT=8 → `halted`=1, `cpu_rst`=1, counters frozen across 10 further cycles; `start` → BOOT with counters and trace cleared.
- `RST` low mid-RUN → `cpu_rst`=1 asynchronously; state IDLE, `trace_count`=0, `rd_*`=0.
- `start` coincident with a PC change in RUN → restart wins; no trace write, `instr_cnt`=0.
